// File: rtl/cla8_seq_ctrl_if.sv
// +-----------------------------------------------------------------------+
// | cla8_seq_ctrl_if : operand/result handshake bundle for cla8_seq_ctrl   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

interface cla8_seq_ctrl_if #(
   parameter int NCHUNK = 4
);
   localparam int c_width = 8 * NCHUNK;

   logic               in_valid;
   logic               in_ready;
   logic [c_width-1:0] A;
   logic [c_width-1:0] B;
   logic               Cin;
   logic               Sub;
   logic               out_valid;
   logic               out_ready;
   logic [c_width-1:0] Sum;
   logic               Cout;
   logic               Ovf;

   modport master (
      output in_valid, A, B, Cin, Sub, out_ready,
      input  in_ready, out_valid, Sum, Cout, Ovf
   );

   modport slave (
      input  in_valid, A, B, Cin, Sub, out_ready,
      output in_ready, out_valid, Sum, Cout, Ovf
   );
endinterface

`default_nettype wire

// File: rtl/cla8_seq_ctrl.sv
// +-----------------------------------------------------------------------+
// | cla8_seq_ctrl : byte-serial wide add/subtract around one CLA_8 adder   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module cla8_seq_ctrl #(
   parameter int NCHUNK = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   cla8_seq_ctrl_if.slave     bus
);
   localparam int                c_width = 8 * NCHUNK;
   localparam int                c_kw    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [c_kw-1:0]   c_last  = c_kw'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [c_kw-1:0]      r_k;
   logic [c_width-1:0]   r_a;
   logic [c_width-1:0]   r_b;
   logic [c_width-1:0]   r_sum;
   logic                 r_carry;
   logic                 r_cout;
   logic                 r_ovf;
   logic [c_kw+2:0]      w_shift;
   logic [7:0]           w_a_chunk;
   logic [7:0]           w_b_chunk;
   logic [7:0]           w_add_sum;
   logic                 w_add_cout;
   logic                 w_last;
   logic [c_width-1:0]   w_sum_next;

   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c[4], p ^ c[3:0]};
   endfunction

   // CLA_8: lookahead low nibble; high nibble precomputed for both carries and selected
   function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic ci);
      logic [4:0] lo;
      logic [4:0] hi0;
      logic [4:0] hi1;
      logic [4:0] hi;
      lo  = cla4(a[3:0], b[3:0], ci);
      hi0 = cla4(a[7:4], b[7:4], 1'b0);
      hi1 = cla4(a[7:4], b[7:4], 1'b1);
      hi  = lo[4] ? hi1 : hi0;
      return {hi, lo[3:0]};
   endfunction

   assign w_shift    = {r_k, 3'b000};
   assign w_a_chunk  = 8'(r_a >> w_shift);
   assign w_b_chunk  = 8'(r_b >> w_shift);
   assign w_last     = (r_k == c_last);
   assign {w_add_cout, w_add_sum} = cla8(w_a_chunk, w_b_chunk, r_carry);
   assign w_sum_next = (r_sum & ~(c_width'(8'hFF) << w_shift))
                     | (c_width'(w_add_sum) << w_shift);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid)  w_next = RUN;
         RUN:     if (w_last)        w_next = DONE;
         DONE:    if (bus.out_ready) w_next = IDLE;
         default:                    w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.A;
                  r_b     <= bus.Sub ? ~bus.B : bus.B;
                  r_carry <= bus.Cin ^ bus.Sub;
                  r_k     <= '0;
               end
            end
            RUN: begin
               r_sum   <= w_sum_next;
               r_carry <= w_add_cout;
               if (w_last) begin
                  r_k    <= '0;
                  r_cout <= w_add_cout;
                  // B operand is already inverted for subtract, so one rule covers both modes
                  r_ovf  <= (r_a[c_width-1] == r_b[c_width-1]) && (w_add_sum[7] != r_a[c_width-1]);
               end else begin
                  r_k <= r_k + c_kw'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.Sum       = r_sum;
   assign bus.Cout      = r_cout;
   assign bus.Ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cla8_seq_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_cla8_seq_ctrl : randomized and directed checks against a reference  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_cla8_seq_ctrl;
   localparam int NCHUNK = 4;
   localparam int W      = 8 * NCHUNK;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   res_t q[$];
   bit   m_idle = 1'b1;
   bit   m_done = 1'b0;
   int   m_cnt  = 0;

   always #5 clk = ~clk;

   cla8_seq_ctrl_if #(.NCHUNK(NCHUNK)) bus ();

   cla8_seq_ctrl #(.NCHUNK(NCHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
      res_t       r;
      logic [W:0] t;
      if (!sub) begin
         t      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
         r.cout = t[W];
         r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      end else begin
         t      = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
         r.cout = ~t[W];
         r.ovf  = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
      end
      r.sum = t[W-1:0];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Cycle-level reference: accept, NCHUNK working cycles, then hold until consumed
   initial begin
      forever begin
         @(posedge clk);
         if (rst_n) begin
            if (m_idle) begin
               if (bus.in_valid) begin
                  q.push_back(ref_op(bus.A, bus.B, bus.Cin, bus.Sub));
                  m_idle = 1'b0;
                  m_cnt  = NCHUNK;
               end
            end else if (m_cnt > 0) begin
               m_cnt--;
               if (m_cnt == 0) m_done = 1'b1;
            end else if (m_done && bus.out_ready) begin
               m_done = 1'b0;
               m_idle = 1'b1;
               void'(q.pop_front());
            end
         end
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            m_idle = 1'b1;
            m_done = 1'b0;
            m_cnt  = 0;
            chk("rst_in_ready",  bus.in_ready,  1);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_sum",       bus.Sum,       0);
            chk("rst_cout",      bus.Cout,      0);
            chk("rst_ovf",       bus.Ovf,       0);
         end else begin
            chk("in_ready",  bus.in_ready,  m_idle);
            chk("out_valid", bus.out_valid, m_done);
            if (m_done && q.size() > 0) begin
               chk("sum",  bus.Sum,  q[0].sum);
               chk("cout", bus.Cout, q[0].cout);
               chk("ovf",  bus.Ovf,  q[0].ovf);
            end
         end
      end
   end

   // Call at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      int n = 0;
      bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub; bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("accept");
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic take(input logic [W-1:0] es, input logic ec, input logic eo, input int lat);
      int n = 0;
      while (!bus.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("result");
      if (lat >= 0) chk("latency", n, lat);
      chk("lit_sum",  bus.Sum,  es);
      chk("lit_cout", bus.Cout, ec);
      chk("lit_ovf",  bus.Ovf,  eo);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("ready_after_xfer", bus.in_ready, 1);
   endtask

   initial begin
      res_t pin;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int n;
      bit xfer;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Sub = 1'b0;

      pin = ref_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
      chk("model_pin_ovf", {pin.ovf, pin.sum}, {1'b1, 32'h80000000});
      pin = ref_op(32'd5, 32'd7, 1'b0, 1'b1);
      chk("model_pin_sub", {pin.cout, pin.sum}, {1'b0, 32'hFFFFFFFE});

      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0); take(32'h00000000, 1'b1, 1'b0, NCHUNK);
      send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0); take(32'h80000000, 1'b0, 1'b1, NCHUNK);
      send(32'd5,        32'd7,        1'b0, 1'b1); take(32'hFFFFFFFE, 1'b0, 1'b0, NCHUNK);
      send(32'd7,        32'd5,        1'b1, 1'b1); take(32'h00000001, 1'b1, 1'b0, NCHUNK);
      send(32'h00FF00FF, 32'h00010001, 1'b1, 1'b0); take(32'h01000101, 1'b0, 1'b0, NCHUNK);

      // Backpressure with competing operands offered
      send(32'h80000000, 32'h80000000, 1'b0, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) timeout("bp_result");
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.A = $urandom; bus.B = $urandom;
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready,  0);
         chk("bp_sum",      bus.Sum,       32'h00000000);
         chk("bp_cout_ovf", {bus.Cout, bus.Ovf}, 2'b11);
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("bp_ready_after", bus.in_ready,  1);
      chk("bp_valid_after", bus.out_valid, 0);

      // Reset in the middle of an operation
      send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_sum",   bus.Sum,       0);
      chk("midrst_flags", {bus.Cout, bus.Ovf}, 2'b00);
      chk("midrst_ready", bus.in_ready,  1);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      send(32'h12345678, 32'h11111111, 1'b0, 1'b0); take(32'h23456789, 1'b0, 1'b0, NCHUNK);

      // Randomized operations with random consumer stalls
      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : W'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 32'h80000000 : W'($urandom);
         send(a, b, 1'(($urandom) & 1), 1'(($urandom) & 1));
         n = 0;
         xfer = 1'b0;
         while (!xfer && n < 200) begin
            bus.out_ready = 1'(($urandom) & 1);
            xfer = bus.out_valid && bus.out_ready;
            @(negedge clk);
            n++;
         end
         bus.out_ready = 1'b0;
         if (!xfer) timeout("rand_xfer");
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
